pipe_hazard_ctrl: RTL and testbench

Central hazard and trap sequencer for the 5-stage pipeline. It drives the stall and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers and the PC source select. It resolves load-use hazards, taken branches, multicycle-EX busy, instruction-memory wait and fetch-side stall. A small FSM sequences trap entry when the memory stage reports an exception and sequences the return when MEM reports `mret`. It sits beside the datapath; its outputs wire directly to the stage registers' stall/flush inputs.

---
 rtl/pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and trap sequencer for the 5-stage pipeline. It drives the stall and
//   flush controls of the stage registers and the PC source select. It resolves
//   load-use, taken-branch, multicycle-EX busy, imem wait and refill stalls.
//   A small FSM sequences trap entry (MEM exception) and mret return.
//
// Ports
//   i_clk, i_rst_n          clock, async active-low reset
//   i_clk_en                FSM/counter advance enable
//   i_rs1_d, i_rs2_d        ID source registers
//   i_rd_e, i_mem_read_e    EX destination / EX is a load
//   i_branch_taken_e        EX taken branch or jump
//   i_div_busy_e            multicycle EX unit busy
//   i_imem_ready_f          instruction memory data valid
//   i_exception_code_m      MEM exception code (P_NO_E = none)
//   i_mret_m                mret at MEM
//   o_pc_stall .. o_ex_mem_flush  stage register controls
//   o_exception_f_stall     fetch-side stall during refill
//   o_pc_sel                00 PC+4, 01 branch, 10 trap vector, 11 mepc
//   o_trap_enter            one-cycle pulse for CSR mepc/mcause capture
//   o_state                 FSM state (debug)
module pipe_hazard_ctrl #(
   parameter logic [3:0] P_NO_E   = 4'd0,
   parameter int         P_REFILL = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clk_en,
   input  logic [4:0] i_rs1_d,
   input  logic [4:0] i_rs2_d,
   input  logic [4:0] i_rd_e,
   input  logic       i_mem_read_e,
   input  logic       i_branch_taken_e,
   input  logic       i_div_busy_e,
   input  logic       i_imem_ready_f,
   input  logic [3:0] i_exception_code_m,
   input  logic       i_mret_m,
   output logic       o_pc_stall,
   output logic       o_if_id_stall,
   output logic       o_if_id_flush,
   output logic       o_id_ex_stall,
   output logic       o_id_ex_flush,
   output logic       o_ex_mem_flush,
   output logic       o_exception_f_stall,
   output logic [1:0] o_pc_sel,
   output logic       o_trap_enter,
   output logic [1:0] o_state
);

   typedef enum logic [1:0] {
      S_RUN      = 2'b00,
      S_TRAP     = 2'b01,
      S_REDIRECT = 2'b10,
      S_REFILL   = 2'b11
   } state_t;

   localparam logic [2:0] LP_CNT_LOAD = 3'(P_REFILL - 1);

   state_t     r_state;
   logic [2:0] r_cnt;
   logic       r_ret;   // redirect target is mepc (mret) rather than trap vector

   logic w_exc;
   logic w_load_use;

   assign w_exc      = (i_exception_code_m != P_NO_E);
   assign w_load_use = i_mem_read_e && (i_rd_e != 5'd0) &&
                       ((i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d));

   // Requests arriving outside RUN are dropped: the flushes already removed them.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_RUN;
         r_cnt   <= 3'd0;
         r_ret   <= 1'b0;
      end else if (i_clk_en) begin
         unique case (r_state)
            S_RUN: begin
               if (w_exc) begin
                  r_state <= S_TRAP;
               end else if (i_mret_m) begin
                  r_state <= S_REDIRECT;
                  r_ret   <= 1'b1;
               end
            end
            S_TRAP: begin
               r_state <= S_REDIRECT;
               r_ret   <= 1'b0;
            end
            S_REDIRECT: begin
               r_state <= S_REFILL;
               r_cnt   <= LP_CNT_LOAD;
            end
            S_REFILL: begin
               if (r_cnt == 3'd0) r_state <= S_RUN;
               else               r_cnt   <= r_cnt - 3'd1;
            end
            default: r_state <= S_RUN;
         endcase
      end
   end

   always_comb begin
      o_pc_stall          = 1'b0;
      o_if_id_stall       = 1'b0;
      o_if_id_flush       = 1'b0;
      o_id_ex_stall       = 1'b0;
      o_id_ex_flush       = 1'b0;
      o_ex_mem_flush      = 1'b0;
      o_exception_f_stall = 1'b0;
      o_pc_sel            = 2'b00;
      o_trap_enter        = 1'b0;
      unique case (r_state)
         S_RUN: begin
            if (w_exc) begin
               // Exception beats a same-cycle branch; PC select stays 00.
               o_if_id_flush  = 1'b1;
               o_id_ex_flush  = 1'b1;
               o_ex_mem_flush = 1'b1;
               o_trap_enter   = 1'b1;
               o_pc_stall     = 1'b1;
            end else if (i_mret_m) begin
               o_if_id_flush  = 1'b1;
               o_id_ex_flush  = 1'b1;
               o_ex_mem_flush = 1'b1;
               o_pc_stall     = 1'b1;
            end else if (i_branch_taken_e) begin
               o_pc_sel      = 2'b01;
               o_if_id_flush = 1'b1;
               o_id_ex_flush = 1'b1;
            end else if (i_div_busy_e) begin
               // Busy freezes ID/EX, so a pending load-use bubble waits for it.
               o_pc_stall    = 1'b1;
               o_if_id_stall = 1'b1;
               o_id_ex_stall = 1'b1;
            end else if (w_load_use) begin
               o_pc_stall    = 1'b1;
               o_if_id_stall = 1'b1;
               o_id_ex_flush = 1'b1;
            end else if (!i_imem_ready_f) begin
               o_pc_stall    = 1'b1;
               o_if_id_flush = 1'b1;
            end
         end
         S_TRAP: begin
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
            o_ex_mem_flush = 1'b1;
            o_pc_stall     = 1'b1;
         end
         S_REDIRECT: begin
            o_pc_sel      = r_ret ? 2'b11 : 2'b10;
            o_if_id_flush = 1'b1;
         end
         S_REFILL: begin
            o_exception_f_stall = 1'b1;
            o_if_id_flush       = 1'b1;
            // Release the PC on the last refill cycle so issue resumes in RUN.
            o_pc_stall          = (r_cnt != 3'd0);
         end
         default: ;
      endcase
   end

   assign o_state = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic       i_clk_en;
   logic [4:0] i_rs1_d, i_rs2_d, i_rd_e;
   logic       i_mem_read_e, i_branch_taken_e, i_div_busy_e, i_imem_ready_f;
   logic [3:0] i_exception_code_m;
   logic       i_mret_m;
   logic       o_pc_stall, o_if_id_stall, o_if_id_flush, o_id_ex_stall;
   logic       o_id_ex_flush, o_ex_mem_flush, o_exception_f_stall, o_trap_enter;
   logic [1:0] o_pc_sel, o_state;

   int vecs = 0;
   int miscmp = 0;
   logic [11:0] exp_v;

   // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
   //  ex_mem_flush, f_stall, trap_enter, pc_sel[1:0], state[1:0]}
   logic [11:0] w_obs;
   assign w_obs = {o_pc_stall, o_if_id_stall, o_if_id_flush, o_id_ex_stall,
                   o_id_ex_flush, o_ex_mem_flush, o_exception_f_stall,
                   o_trap_enter, o_pc_sel, o_state};

   pipe_hazard_ctrl #(.P_NO_E(4'd0), .P_REFILL(2)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clk_en(i_clk_en),
      .i_rs1_d(i_rs1_d), .i_rs2_d(i_rs2_d), .i_rd_e(i_rd_e),
      .i_mem_read_e(i_mem_read_e), .i_branch_taken_e(i_branch_taken_e),
      .i_div_busy_e(i_div_busy_e), .i_imem_ready_f(i_imem_ready_f),
      .i_exception_code_m(i_exception_code_m), .i_mret_m(i_mret_m),
      .o_pc_stall(o_pc_stall), .o_if_id_stall(o_if_id_stall),
      .o_if_id_flush(o_if_id_flush), .o_id_ex_stall(o_id_ex_stall),
      .o_id_ex_flush(o_id_ex_flush), .o_ex_mem_flush(o_ex_mem_flush),
      .o_exception_f_stall(o_exception_f_stall), .o_pc_sel(o_pc_sel),
      .o_trap_enter(o_trap_enter), .o_state(o_state)
   );

   always #5 i_clk = ~i_clk;

   task automatic idle();
      i_clk_en = 1'b1; i_rs1_d = 5'd0; i_rs2_d = 5'd0; i_rd_e = 5'd0;
      i_mem_read_e = 1'b0; i_branch_taken_e = 1'b0; i_div_busy_e = 1'b0;
      i_imem_ready_f = 1'b1; i_exception_code_m = 4'd0; i_mret_m = 1'b0;
   endtask

   // Inputs change 1 time unit after the rising edge; checks 2 units later.
   task automatic tick();
      @(posedge i_clk); #1;
   endtask

   task automatic test_reset();
      idle();
      i_rst_n = 1'b0;
      #3;
      exp_v = 12'b0_0_0_0_0_0_0_0_00_00; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL reset obs=%b exp=%b", w_obs, exp_v); end
      tick(); i_rst_n = 1'b1;
      tick(); #2;
      vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL reset_idle obs=%b exp=%b", w_obs, exp_v); end
   endtask

   task automatic test_load_use();
      tick(); i_mem_read_e = 1'b1; i_rd_e = 5'd5; i_rs2_d = 5'd5; #2;
      exp_v = 12'b1_1_0_0_1_0_0_0_00_00; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL lu_rs2 obs=%b exp=%b", w_obs, exp_v); end
      tick(); i_rs2_d = 5'd0; i_rs1_d = 5'd5; #2;
      vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL lu_rs1 obs=%b exp=%b", w_obs, exp_v); end
      tick(); i_rd_e = 5'd0; i_rs1_d = 5'd0; i_rs2_d = 5'd0; #2;
      exp_v = 12'b0_0_0_0_0_0_0_0_00_00; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL lu_rd0 obs=%b exp=%b", w_obs, exp_v); end
      tick(); i_rd_e = 5'd7; i_rs1_d = 5'd6; i_rs2_d = 5'd8; #2;
      vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL lu_nomatch obs=%b exp=%b", w_obs, exp_v); end
      idle();
   endtask

   task automatic test_branch();
      tick(); i_branch_taken_e = 1'b1; #2;
      exp_v = 12'b0_0_1_0_1_0_0_0_01_00; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL branch obs=%b exp=%b", w_obs, exp_v); end
      tick(); i_branch_taken_e = 1'b0; #2;
      exp_v = 12'b0_0_0_0_0_0_0_0_00_00; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL branch_after obs=%b exp=%b", w_obs, exp_v); end
   endtask

   task automatic test_imem_wait();
      tick(); i_imem_ready_f = 1'b0; #2;
      exp_v = 12'b1_0_1_0_0_0_0_0_00_00; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL imem_wait obs=%b exp=%b", w_obs, exp_v); end
      idle();
   endtask

   task automatic test_trap();
      tick(); i_exception_code_m = 4'd2; i_branch_taken_e = 1'b1; #2;
      exp_v = 12'b1_0_1_0_1_1_0_1_00_00; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL trap_t0 obs=%b exp=%b", w_obs, exp_v); end
      // A late mret during the sequence must be ignored.
      tick(); i_exception_code_m = 4'd0; i_branch_taken_e = 1'b0; i_mret_m = 1'b1; #2;
      exp_v = 12'b1_0_1_0_1_1_0_0_00_01; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL trap_t1 obs=%b exp=%b", w_obs, exp_v); end
      tick(); #2;
      exp_v = 12'b0_0_1_0_0_0_0_0_10_10; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL trap_redirect obs=%b exp=%b", w_obs, exp_v); end
      tick(); #2;
      exp_v = 12'b1_0_1_0_0_0_1_0_00_11; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL trap_refill1 obs=%b exp=%b", w_obs, exp_v); end
      tick(); i_mret_m = 1'b0; #2;
      exp_v = 12'b0_0_1_0_0_0_1_0_00_11; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL trap_refill2 obs=%b exp=%b", w_obs, exp_v); end
      tick(); #2;
      exp_v = 12'b0_0_0_0_0_0_0_0_00_00; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL trap_run obs=%b exp=%b", w_obs, exp_v); end
   endtask

   task automatic test_mret();
      tick(); i_mret_m = 1'b1; #2;
      exp_v = 12'b1_0_1_0_1_1_0_0_00_00; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL mret_run obs=%b exp=%b", w_obs, exp_v); end
      tick(); i_mret_m = 1'b0; #2;
      exp_v = 12'b0_0_1_0_0_0_0_0_11_10; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL mret_redirect obs=%b exp=%b", w_obs, exp_v); end
      tick(); #2;
      exp_v = 12'b1_0_1_0_0_0_1_0_00_11; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL mret_refill1 obs=%b exp=%b", w_obs, exp_v); end
      tick(); #2;
      exp_v = 12'b0_0_1_0_0_0_1_0_00_11; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL mret_refill2 obs=%b exp=%b", w_obs, exp_v); end
      tick(); #2;
      exp_v = 12'b0_0_0_0_0_0_0_0_00_00; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL mret_run_after obs=%b exp=%b", w_obs, exp_v); end
   endtask

   task automatic test_div_load_use();
      tick(); i_div_busy_e = 1'b1; i_mem_read_e = 1'b1; i_rd_e = 5'd9; i_rs1_d = 5'd9;
      for (int c = 0; c < 4; c++) begin
         if (c != 0) tick();
         #2;
         exp_v = 12'b1_1_0_1_0_0_0_0_00_00; vecs++;
         if (w_obs !== exp_v) begin miscmp++; $display("FAIL div_busy_c%0d obs=%b exp=%b", c, w_obs, exp_v); end
      end
      tick(); i_div_busy_e = 1'b0; #2;
      exp_v = 12'b1_1_0_0_1_0_0_0_00_00; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL div_then_lu obs=%b exp=%b", w_obs, exp_v); end
      idle();
   endtask

   task automatic test_clk_en();
      tick(); i_exception_code_m = 4'd3; #2;
      tick(); i_exception_code_m = 4'd0; #2;  // now in TRAP
      i_clk_en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick(); #2;
         exp_v = 12'b1_0_1_0_1_1_0_0_00_01; vecs++;
         if (w_obs !== exp_v) begin miscmp++; $display("FAIL clk_en_hold_c%0d obs=%b exp=%b", c, w_obs, exp_v); end
      end
      i_clk_en = 1'b1;
      tick(); #2;
      exp_v = 12'b0_0_1_0_0_0_0_0_10_10; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL clk_en_resume obs=%b exp=%b", w_obs, exp_v); end
      tick(); tick(); tick(); #2;
      exp_v = 12'b0_0_0_0_0_0_0_0_00_00; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL clk_en_run obs=%b exp=%b", w_obs, exp_v); end
   endtask

   task automatic test_reset_refill();
      tick(); i_mret_m = 1'b1;
      tick(); i_mret_m = 1'b0;          // REDIRECT
      tick(); #2;                        // REFILL
      exp_v = 12'b1_0_1_0_0_0_1_0_00_11; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL rst_pre_refill obs=%b exp=%b", w_obs, exp_v); end
      i_rst_n = 1'b0; #1;                // no clock edge in between
      exp_v = 12'b0_0_0_0_0_0_0_0_00_00; vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL rst_async obs=%b exp=%b", w_obs, exp_v); end
      tick(); i_rst_n = 1'b1;
      tick(); #2;
      vecs++;
      if (w_obs !== exp_v) begin miscmp++; $display("FAIL rst_release obs=%b exp=%b", w_obs, exp_v); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_imem_wait();
      test_trap();
      test_mret();
      test_div_load_use();
      test_clk_en();
      test_reset_refill();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
      $finish;
   end

endmodule
